// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: S-box init, key scheduling and keystream generation over an
// external 256x8 S RAM, XORing plaintext RAM bytes into a ciphertext RAM image.
module rc4_encrypt_core #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [23:0] key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic        s_rden,
  input  logic [7:0]  s_q,
  output logic [4:0]  pt_address,
  output logic        pt_rden,
  input  logic [7:0]  pt_q,
  output logic [4:0]  ct_address,
  output logic [7:0]  ct_data,
  output logic        ct_wren
);

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RD_I, ST_K_WT_I, ST_K_CP_I,
    ST_K_RD_J, ST_K_WT_J, ST_K_CP_J,
    ST_K_WR_I, ST_K_WR_J,
    ST_P_INC,
    ST_P_RD_I, ST_P_WT_I, ST_P_CP_I,
    ST_P_RD_J, ST_P_WT_J, ST_P_CP_J,
    ST_P_WR_I, ST_P_WR_J,
    ST_P_RD_F, ST_P_WT_F, ST_P_WR_C,
    ST_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_si;
  logic [7:0]  r_sj;
  logic [4:0]  r_k;
  logic [1:0]  r_kidx;
  logic [23:0] r_key;
  logic [7:0]  w_keybyte;

  always_comb begin
    case (r_kidx)
      2'd0:    w_keybyte = r_key[23:16];
      2'd1:    w_keybyte = r_key[15:8];
      default: w_keybyte = r_key[7:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_INIT;
      ST_INIT:   if (r_i == 8'hFF) w_next = ST_K_RD_I;
      ST_K_RD_I: w_next = ST_K_WT_I;
      ST_K_WT_I: w_next = ST_K_CP_I;
      ST_K_CP_I: w_next = ST_K_RD_J;
      ST_K_RD_J: w_next = ST_K_WT_J;
      ST_K_WT_J: w_next = ST_K_CP_J;
      ST_K_CP_J: w_next = ST_K_WR_I;
      ST_K_WR_I: w_next = ST_K_WR_J;
      ST_K_WR_J: w_next = (r_i == 8'hFF) ? ST_P_INC : ST_K_RD_I;
      ST_P_INC:  w_next = ST_P_RD_I;
      ST_P_RD_I: w_next = ST_P_WT_I;
      ST_P_WT_I: w_next = ST_P_CP_I;
      ST_P_CP_I: w_next = ST_P_RD_J;
      ST_P_RD_J: w_next = ST_P_WT_J;
      ST_P_WT_J: w_next = ST_P_CP_J;
      ST_P_CP_J: w_next = ST_P_WR_I;
      ST_P_WR_I: w_next = ST_P_WR_J;
      ST_P_WR_J: w_next = ST_P_RD_F;
      ST_P_RD_F: w_next = ST_P_WT_F;
      ST_P_WT_F: w_next = ST_P_WR_C;
      ST_P_WR_C: w_next = (r_k == LAST_K) ? ST_DONE : ST_P_INC;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (stop && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_si   <= 8'd0;
      r_sj   <= 8'd0;
      r_k    <= 5'd0;
      r_kidx <= 2'd0;
      r_key  <= 24'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key  <= key;
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_k    <= 5'd0;
            r_kidx <= 2'd0;
          end
        end
        ST_INIT: begin
          r_i <= r_i + 8'd1;
          if (r_i == 8'hFF) begin
            r_j    <= 8'd0;
            r_kidx <= 2'd0;
          end
        end
        ST_K_CP_I: begin
          r_si <= s_q;
          r_j  <= r_j + s_q + w_keybyte;
        end
        ST_K_CP_J, ST_P_CP_J: r_sj <= s_q;
        ST_K_WR_J: begin
          r_i    <= r_i + 8'd1;
          r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
          if (r_i == 8'hFF) begin
            r_j <= 8'd0;
            r_k <= 5'd0;
          end
        end
        ST_P_INC: r_i <= r_i + 8'd1;
        ST_P_CP_I: begin
          r_si <= s_q;
          r_j  <= r_j + s_q;
        end
        ST_P_WR_C: r_k <= r_k + 5'd1;
        default: ;
      endcase
    end
  end

  // Memory-port controls decode from the current state only; the final XOR
  // is taken directly from the two read ports in the write cycle.
  always_comb begin
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_DONE);
    s_address  = 8'd0;
    s_data     = 8'd0;
    s_wren     = 1'b0;
    s_rden     = 1'b0;
    pt_address = 5'd0;
    pt_rden    = 1'b0;
    ct_address = 5'd0;
    ct_data    = 8'd0;
    ct_wren    = 1'b0;
    case (r_state)
      ST_INIT: begin
        s_address = r_i;
        s_data    = r_i;
        s_wren    = 1'b1;
      end
      ST_K_RD_I, ST_P_RD_I: begin
        s_address = r_i;
        s_rden    = 1'b1;
      end
      ST_K_RD_J, ST_P_RD_J: begin
        s_address = r_j;
        s_rden    = 1'b1;
      end
      ST_K_WR_I, ST_P_WR_I: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
      end
      ST_K_WR_J, ST_P_WR_J: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
      end
      ST_P_RD_F: begin
        s_address  = r_si + r_sj;
        s_rden     = 1'b1;
        pt_address = r_k;
        pt_rden    = 1'b1;
      end
      ST_P_WR_C: begin
        ct_address = r_k;
        ct_data    = s_q ^ pt_q;
        ct_wren    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Self-checking bench for rc4_encrypt_core: synchronous RAM models, a plain
// software RC4 reference, cycle-accurate timing checks and abort/reset cases.
module tb_rc4_encrypt_core;

  localparam int L        = 9;
  localparam int DONE_CYC = 2305 + 12 * L;

  typedef logic [7:0] msg_t [32];

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic [23:0] key     = 24'd0;
  logic        busy, done, s_wren, s_rden, pt_rden, ct_wren;
  logic [7:0]  s_address, s_data, ct_data;
  logic [4:0]  pt_address, ct_address;
  logic [7:0]  s_q, s_pipe, pt_q, pt_pipe;
  logic [7:0]  s_mem  [256];
  logic [7:0]  pt_mem [32];

  int n_checks   = 0;
  int n_errors   = 0;
  int proto_viol = 0;

  wire [39:0] w_outs = {busy, done, s_wren, s_rden, pt_rden, ct_wren,
                        s_address, s_data, pt_address, ct_address, ct_data};

  always #5 clk = ~clk;

  rc4_encrypt_core #(.MSG_LEN(L)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .key(key),
    .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_rden(s_rden), .s_q(s_q),
    .pt_address(pt_address), .pt_rden(pt_rden), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren)
  );

  // Two register stages: address in cycle t gives data in cycle t+2.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_data;
    s_pipe  <= s_mem[s_address];
    s_q     <= s_pipe;
    pt_pipe <= pt_mem[pt_address];
    pt_q    <= pt_pipe;
  end

  always @(negedge clk) if (s_wren && s_rden) proto_viol++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void rc4_model(input logic [23:0] k, input msg_t pt, output msg_t ct);
    int s [256];
    int kb [3];
    int i, j, t;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    for (int n = 0; n < 32; n++) ct[n] = 8'd0;
    i = 0;
    j = 0;
    for (int n = 0; n < L; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ct[n] = 8'(s[(s[i] + s[j]) % 256]) ^ pt[n];
    end
  endfunction

  // Starts one encryption and follows it cycle by cycle. A non-zero
  // stop_at / glitch_at / reset_at injects that event in the given cycle.
  task automatic run(input string tag, input logic [23:0] k, input msg_t exp_ct,
                     input int stop_at, input int glitch_at, input int reset_at);
    msg_t got;
    int   dn, nwr, init_err, busy_err, ct_err, quiet_err;
    bit   ended;
    dn = 0; nwr = 0; init_err = 0; busy_err = 0; ct_err = 0; quiet_err = 0;
    ended = 1'b0;
    for (int a = 0; a < 32; a++) got[a] = 8'h00;
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= DONE_CYC + 20; n++) begin
      if (n <= 256 && !(s_wren === 1'b1 && s_rden === 1'b0 &&
                        s_address === 8'(n - 1) && s_data === 8'(n - 1)))
        init_err++;
      if (busy !== 1'b1) busy_err++;
      if (ct_wren === 1'b1) begin
        if (n != 2304 + 12 * (int'(ct_address) + 1)) ct_err++;
        got[ct_address] = ct_data;
        nwr++;
      end
      if (done === 1'b1) begin
        dn = n;
        break;
      end
      if (n == glitch_at) begin
        key   = ~k;
        start = 1'b1;
      end
      if (n == reset_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_async_rst_outs"}, 64'(w_outs), 64'd0);
        @(posedge clk); #1;
        check({tag, "_rst_held_outs"}, 64'(w_outs), 64'd0);
        reset_n = 1'b1;
        ended   = 1'b1;
        break;
      end
      if (n == stop_at) stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (stop) begin
        stop = 1'b0;
        check({tag, "_stop_busy_done"}, 64'({busy, done}), 64'd0);
        check({tag, "_stop_enables"}, 64'({s_wren, s_rden, pt_rden, ct_wren}), 64'd0);
        repeat (30) begin
          @(posedge clk); #1;
          if (busy !== 1'b0 || done !== 1'b0) quiet_err++;
        end
        check({tag, "_stop_quiet"}, 64'(quiet_err), 64'd0);
        ended = 1'b1;
        break;
      end
    end
    check({tag, "_init_writes"}, 64'(init_err), 64'd0);
    check({tag, "_busy_high"}, 64'(busy_err), 64'd0);
    if (!ended) begin
      check({tag, "_done_cycle"}, 64'(dn), 64'(DONE_CYC));
      check({tag, "_ct_timing"}, 64'(ct_err), 64'd0);
      check({tag, "_ct_writes"}, 64'(nwr), 64'(L));
      for (int a = 0; a < L; a++)
        check($sformatf("%s_ct[%0d]", tag, a), 64'(got[a]), 64'(exp_ct[a]));
      @(posedge clk); #1;
      check({tag, "_idle_after_done"}, 64'({busy, done}), 64'd0);
    end
    check({tag, "_proto"}, 64'(proto_viol), 64'd0);
  endtask

  task automatic load_random_text(input logic [23:0] k, input bit letters, output msg_t exp);
    msg_t pt;
    for (int a = 0; a < 32; a++) begin
      if (a >= L)       pt[a] = 8'h00;
      else if (!letters) pt[a] = 8'($urandom);
      else if ($urandom_range(0, 5) == 0) pt[a] = 8'h20;
      else              pt[a] = 8'($urandom_range(97, 122));
      pt_mem[a] = pt[a];
    end
    rc4_model(k, pt, exp);
  endtask

  initial begin
    msg_t        exp;
    logic [71:0] ptxt;
    logic [71:0] ctxt;
    logic [23:0] k;

    #2 reset_n = 1'b0;
    #1 check("reset_outs", 64'(w_outs), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("reset_hold_outs", 64'(w_outs), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    ptxt = "Plaintext";
    ctxt = 72'hBBF316E8D940AF0AD3;
    for (int a = 0; a < 32; a++) begin
      pt_mem[a] = 8'h00;
      exp[a]    = 8'h00;
    end
    for (int a = 0; a < L; a++) begin
      pt_mem[a] = ptxt[71 - 8 * a -: 8];
      exp[a]    = ctxt[71 - 8 * a -: 8];
    end
    run("kat_glitch", 24'h4B6579, exp, 0, 500, 0);

    for (int r = 0; r < 3; r++) begin
      k = 24'($urandom);
      load_random_text(k, 1'b1, exp);
      run($sformatf("rand%0d", r), k, exp, 0, 0, 0);
    end

    load_random_text(24'hFFFFFF, 1'b0, exp);
    run("key_ff", 24'hFFFFFF, exp, 0, 0, 0);

    k = 24'h000249;
    load_random_text(k, 1'b1, exp);
    run("stop_mid", k, exp, 1000, 0, 0);
    run("after_stop", k, exp, 0, 0, 0);

    k = 24'($urandom);
    load_random_text(k, 1'b1, exp);
    run("reset_mid", k, exp, 0, 0, 2400);
    @(posedge clk); #1;
    run("after_reset", k, exp, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
